// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit CPU datapath with a priority bus mux, GPR file and Y/Z ALU.
// Define DATAPATH_MULDIV_EN to build the signed mul/div opcodes; otherwise they yield Z=0.
module cpu_datapath #(
  parameter int PC_INC = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        PCin, IRin, HIin, LOin, MARin, MDRin, Yin, Zin, Cin, InPortin,
  input  logic        PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut, Cout,
  input  logic        Read,
  input  logic        incPC,
  input  logic [4:0]  opcode,
  input  logic [31:0] Mdatain,
  input  logic [31:0] InPort_data,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MAR_q,
  output logic [31:0] IR_q
);
  logic [15:0] r_in, r_out;
  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] pc_q, pc_d, hi_q, hi_d, lo_q, lo_d, y_q, y_d, mdr_q, mdr_d;
  logic [31:0] inport_q, inport_d, c_q, c_d, IR_d, MAR_d;
  logic [63:0] z_q, z_d;
  logic [31:0] bus, zl, zh, rot_r, rot_l;
  logic [4:0]  sh;
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign BusMuxOut = bus;
  assign sh = bus[4:0];
  assign rot_r = 32'({y_q, y_q} >> sh);
  assign rot_l = 32'(({y_q, y_q} << sh) >> 32);
`ifdef DATAPATH_MULDIV_EN
  logic [63:0] prod;
  logic [31:0] quo, rem;
  assign prod = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
  assign quo  = (bus == '0) ? '1  : $signed(y_q) / $signed(bus);
  assign rem  = (bus == '0) ? y_q : $signed(y_q) % $signed(bus);
`endif
  // Later assignments win, so sources are listed from lowest to highest priority.
  always_comb begin
    bus = '0;
    if (Cout) bus = c_q;
    if (InPortOut) bus = inport_q;
    if (MDRout) bus = mdr_q;
    if (PCout) bus = pc_q;
    if (ZLowOut) bus = z_q[31:0];
    if (ZHighOut) bus = z_q[63:32];
    if (LOout) bus = lo_q;
    if (HIout) bus = hi_q;
    for (int i = 15; i >= 0; i--) if (r_out[i]) bus = r_q[i];
  end
  always_comb begin
    zh = '0;
    zl = '0;
    if (incPC) zl = bus + 32'(PC_INC);
    else
      case (opcode)
        5'b00011: zl = y_q + bus;
        5'b00100: zl = y_q - bus;
        5'b00101: zl = y_q >> sh;
        5'b00110: zl = $signed(y_q) >>> sh;
        5'b00111: zl = y_q << sh;
        5'b01000: zl = rot_r;
        5'b01001: zl = rot_l;
        5'b01010: zl = y_q & bus;
        5'b01011: zl = y_q | bus;
`ifdef DATAPATH_MULDIV_EN
        5'b01111: {zh, zl} = prod;
        5'b10000: {zh, zl} = {rem, quo};
`endif
        5'b10001: zl = -bus;
        5'b10010: zl = ~bus;
        default: ;
      endcase
  end
  always_comb begin
    for (int i = 0; i < 16; i++) r_d[i] = r_in[i] ? bus : r_q[i];
    pc_d     = PCin ? bus : pc_q;
    IR_d     = IRin ? bus : IR_q;
    hi_d     = HIin ? bus : hi_q;
    lo_d     = LOin ? bus : lo_q;
    MAR_d    = MARin ? bus : MAR_q;
    y_d      = Yin ? bus : y_q;
    mdr_d    = MDRin ? (Read ? Mdatain : bus) : mdr_q;
    inport_d = InPortin ? InPort_data : inport_q;
    c_d      = Cin ? {{13{IR_q[18]}}, IR_q[18:0]} : c_q;
    z_d      = Zin ? {zh, zl} : z_q;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q     <= '0;
      IR_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      MAR_q    <= '0;
      y_q      <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      c_q      <= '0;
      z_q      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      pc_q     <= pc_d;
      IR_q     <= IR_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      MAR_q    <= MAR_d;
      y_q      <= y_d;
      mdr_q    <= mdr_d;
      inport_q <= inport_d;
      c_q      <= c_d;
      z_q      <= z_d;
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: randomized self-checking bench for cpu_datapath against a behavioural model.
// Expectations for mul/div follow DATAPATH_MULDIV_EN.
module tb_cpu_datapath;
`ifdef DATAPATH_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  typedef struct packed {logic [4:0] op; logic [31:0] a, b, zl, zh;} vec_t;
  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] r_in, r_out;
  logic        PCin, IRin, HIin, LOin, MARin, MDRin, Yin, Zin, Cin, InPortin;
  logic        PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut, Cout;
  logic        Read, incPC;
  logic [4:0]  opcode;
  logic [31:0] Mdatain, InPort_data, BusMuxOut, MAR_q, IR_q;
  logic [31:0] m_r [16];
  int n_cmp = 0, n_err = 0;

  cpu_datapath #(.PC_INC(1)) dut (
    .clk(clk), .clr(clr),
    .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
    .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
    .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
    .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .Cin(Cin), .InPortin(InPortin),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut),
    .MDRout(MDRout), .InPortOut(InPortOut), .Cout(Cout),
    .Read(Read), .incPC(incPC), .opcode(opcode), .Mdatain(Mdatain), .InPort_data(InPort_data),
    .BusMuxOut(BusMuxOut), .MAR_q(MAR_q), .IR_q(IR_q)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, b);
    logic [31:0] t;
    int n, q;
    longint p;
    n = int'(b[4:0]);
    t = a;
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  begin repeat (n) t = {1'b0, t[31:1]}; return {32'd0, t}; end
      5'd6:  begin repeat (n) t = {t[31], t[31:1]}; return {32'd0, t}; end
      5'd7:  begin repeat (n) t = {t[30:0], 1'b0}; return {32'd0, t}; end
      5'd8:  begin repeat (n) t = {t[0], t[31:1]}; return {32'd0, t}; end
      5'd9:  begin repeat (n) t = {t[30:0], t[31]}; return {32'd0, t}; end
      5'd10: return {32'd0, a & b};
      5'd11: return {32'd0, a | b};
      5'd15: begin
        if (!MD) return 64'd0;
        p = longint'(int'(a)) * longint'(int'(b));
        return p;
      end
      5'd16: begin
        if (!MD) return 64'd0;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = int'(a) / int'(b);
        return {32'(int'(a) - q * int'(b)), 32'(q)};
      end
      5'd17: return {32'd0, 32'd0 - b};
      5'd18: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic idle();
    r_in = '0; r_out = '0;
    {PCin, IRin, HIin, LOin, MARin, MDRin, Yin, Zin, Cin, InPortin} = '0;
    {PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut, Cout} = '0;
    Read = 0; incPC = 0; opcode = '0; Mdatain = '0; InPort_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_gpr(input int n, input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    step();
    MDRout = 1; r_in[n] = 1;
    step();
    m_r[n] = v;
  endtask

  task automatic rd_gpr(input int n, output logic [31:0] v);
    r_out[n] = 1;
    #1 v = BusMuxOut;
    idle();
  endtask

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, b, output logic [31:0] zl, zh);
    load_gpr(14, a);
    load_gpr(15, b);
    r_out[14] = 1; Yin = 1;
    step();
    r_out[15] = 1; opcode = op; Zin = 1;
    step();
    ZLowOut = 1;
    #1 zl = BusMuxOut;
    idle();
    ZHighOut = 1;
    #1 zh = BusMuxOut;
    idle();
  endtask

  task automatic test_reset();
    clr = 1; idle();
    #3 clr = 0;
    r_out[2] = 1;
    #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_err++; $display("FAIL reset_bus: got %h want 0", BusMuxOut); end
    n_cmp++;
    if ({MAR_q, IR_q} !== 64'd0) begin n_err++; $display("FAIL reset_mar_ir: got %h/%h want 0", MAR_q, IR_q); end
    @(negedge clk) clr = 1;
    idle();
    step();
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_err++; $display("FAIL idle_bus: got %h want 0", BusMuxOut); end
    for (int i = 0; i < 16; i++) m_r[i] = '0;
  endtask

  task automatic test_or_seq();
    logic [31:0] v;
    load_gpr(2, 32'd4);
    load_gpr(3, 32'd2);
    rd_gpr(2, v);
    n_cmp++;
    if (v !== 32'd4) begin n_err++; $display("FAIL r2_load: got %h want 4", v); end
    PCout = 1; incPC = 1; Zin = 1;
    step();
    ZLowOut = 1; PCin = 1;
    step();
    PCout = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== 32'd1) begin n_err++; $display("FAIL pc_inc: got %h want 1", v); end
    r_out[2] = 1; Yin = 1;
    step();
    r_out[3] = 1; opcode = 5'b01011; Zin = 1;
    step();
    ZLowOut = 1; r_in[1] = 1;
    step();
    m_r[1] = 32'd6;
    rd_gpr(1, v);
    n_cmp++;
    if (v !== 32'd6) begin n_err++; $display("FAIL or_r1: got %h want 6", v); end
  endtask

  task automatic test_gpr_random();
    logic [31:0] v;
    int i, j;
    for (int k = 0; k < 16; k++) load_gpr(k, $urandom);
    for (int k = 0; k < 16; k++) begin
      rd_gpr(k, v);
      n_cmp++;
      if (v !== m_r[k]) begin n_err++; $display("FAIL gpr_rd[%0d]: got %h want %h", k, v, m_r[k]); end
    end
    for (int k = 0; k < 12; k++) begin
      i = $urandom_range(0, 15);
      j = $urandom_range(0, 15);
      r_out[i] = 1; r_out[j] = 1; HIout = 1; Cout = 1;
      #1 v = BusMuxOut;
      idle();
      n_cmp++;
      if (v !== m_r[i < j ? i : j]) begin
        n_err++; $display("FAIL bus_prio R%0d/R%0d: got %h want %h", i, j, v, m_r[i < j ? i : j]);
      end
    end
  endtask

  task automatic test_alu_vectors();
    vec_t tv [13];
    logic [31:0] zl, zh;
    tv[0]  = '{5'd3,  32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFE, 32'd0};
    tv[1]  = '{5'd4,  32'd7, 32'hFFFF_FFF7, 32'd16, 32'd0};
    tv[2]  = '{5'd6,  32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0};
    tv[3]  = '{5'd15, 32'd16, 32'hFFFF_FFFE, MD ? 32'hFFFF_FFE0 : 32'd0, MD ? 32'hFFFF_FFFF : 32'd0};
    tv[4]  = '{5'd16, 32'd16, 32'hFFFF_FFFE, MD ? 32'hFFFF_FFF8 : 32'd0, 32'd0};
    tv[5]  = '{5'd16, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFD : 32'd0, MD ? 32'hFFFF_FFFF : 32'd0};
    tv[6]  = '{5'd16, 32'd5, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0, MD ? 32'd5 : 32'd0};
    tv[7]  = '{5'd8,  32'd1, 32'd1, 32'h8000_0000, 32'd0};
    tv[8]  = '{5'd9,  32'h8000_0000, 32'd1, 32'd1, 32'd0};
    tv[9]  = '{5'd7,  32'd1, 32'd31, 32'h8000_0000, 32'd0};
    tv[10] = '{5'd17, 32'd0, 32'd5, 32'hFFFF_FFFB, 32'd0};
    tv[11] = '{5'd5,  32'h8000_0000, 32'd36, 32'h0800_0000, 32'd0};
    tv[12] = '{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int k = 0; k < 13; k++) begin
      alu_run(tv[k].op, tv[k].a, tv[k].b, zl, zh);
      n_cmp++;
      if ({zh, zl} !== {tv[k].zh, tv[k].zl}) begin
        n_err++; $display("FAIL alu_vec[%0d] op=%0d: got %h_%h want %h_%h", k, tv[k].op, zh, zl, tv[k].zh, tv[k].zl);
      end
    end
  endtask

  task automatic test_alu_random();
    int ops [16] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 0, 12, 31};
    logic [4:0] op;
    logic [31:0] a, b, zl, zh;
    logic [63:0] exp;
    for (int k = 0; k < 60; k++) begin
      op = 5'(ops[$urandom_range(0, 15)]);
      a = $urandom;
      b = $urandom;
      if (op == 5'd16) begin
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 50));
        if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
      end
      exp = ref_alu(op, a, b);
      alu_run(op, a, b, zl, zh);
      n_cmp++;
      if ({zh, zl} !== exp) begin
        n_err++; $display("FAIL alu_rand op=%0d a=%h b=%h: got %h_%h want %h", op, a, b, zh, zl, exp);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] v, x;
    x = {$urandom_range(0, 8191), 19'h40000};
    load_gpr(6, x);
    r_out[6] = 1; IRin = 1; MARin = 1;
    step();
    n_cmp++;
    if ({IR_q, MAR_q} !== {x, x}) begin n_err++; $display("FAIL ir_mar_load: got %h/%h want %h", IR_q, MAR_q, x); end
    Cin = 1;
    step();
    Cout = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== 32'hFFFC_0000) begin n_err++; $display("FAIL c_sext: got %h want fffc0000", v); end
    x = $urandom;
    InPort_data = x; InPortin = 1;
    step();
    InPortOut = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== x) begin n_err++; $display("FAIL inport: got %h want %h", v, x); end
    load_gpr(7, $urandom);
    load_gpr(8, $urandom);
    r_out[7] = 1; HIin = 1;
    step();
    r_out[8] = 1; LOin = 1;
    step();
    HIout = 1; LOout = 1; MDRout = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== m_r[7]) begin n_err++; $display("FAIL hi_prio: got %h want %h", v, m_r[7]); end
    LOout = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== m_r[8]) begin n_err++; $display("FAIL lo_rd: got %h want %h", v, m_r[8]); end
    r_out[9] = 1; MDRin = 1; Read = 0; Mdatain = ~m_r[9];
    step();
    MDRout = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== m_r[9]) begin n_err++; $display("FAIL mdr_bus: got %h want %h", v, m_r[9]); end
    r_out[4] = 1; r_in[4] = 1;
    step();
    rd_gpr(4, v);
    n_cmp++;
    if (v !== m_r[4]) begin n_err++; $display("FAIL self_load: got %h want %h", v, m_r[4]); end
    r_out[5] = 1; incPC = 1; opcode = 5'b00100; Zin = 1;
    step();
    ZLowOut = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== m_r[5] + 32'd1) begin n_err++; $display("FAIL incpc_override: got %h want %h", v, m_r[5] + 32'd1); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] v;
    load_gpr(1, $urandom | 32'd1);
    r_out[1] = 1; Yin = 1; r_in[2] = 1;
    #2 clr = 0;
    #1 v = BusMuxOut;
    n_cmp++;
    if (v !== 32'd0) begin n_err++; $display("FAIL midrst_bus: got %h want 0", v); end
    @(negedge clk) clr = 1;
    idle();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    rd_gpr(1, v);
    n_cmp++;
    if (v !== 32'd0) begin n_err++; $display("FAIL midrst_r1: got %h want 0", v); end
    ZLowOut = 1; PCout = 1;
    #1 v = BusMuxOut;
    idle();
    n_cmp++;
    if (v !== 32'd0) begin n_err++; $display("FAIL midrst_z: got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_or_seq();
    test_gpr_random();
    test_alu_vectors();
    test_alu_random();
    test_regs();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
